sobel_param: RTL and testbench
==============================

SOBEL_PARAM -- requirements
Module: sobel_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width.
REQ-002 SHALL have parameter OUT_W, default 11: magnitude output width, range 1..DATA_W+3.
REQ-003 SHALL have derived localparams MAG_W = DATA_W+3 and LAT = MAG_W+4.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 matrix_p11..matrix_p33  input  DATA_W each  3x3 window, row-major, p22 centre.
REQ-007 mean_en  input  1  window valid, sampled every cycle.
REQ-008 mode  input  1  0 = L1 (|gx|+|gy|), 1 = L2 (floor sqrt(gx²+gy²)).
REQ-009 threshold  input  OUT_W  edge threshold.
REQ-010 sobel_data  output  OUT_W  saturated gradient magnitude.
REQ-011 edge_bit  output  1  sobel_data >= threshold.
REQ-012 display_val  output  1  sobel_data and edge_bit valid.

Function
REQ-013 SHALL compute gx = (p31+2·p32+p33) − (p11+2·p12+p13) and gy = (p11+2·p21+p31) − (p13+2·p23+p33), taking absolute values in DATA_W+2 bits with no overflow.
REQ-014 SHALL pipeline the block fully at one sample per cycle with no stall and no bubble.
REQ-015 Stage 1 SHALL register the four partial sums; stage 2 SHALL register |gx| and |gy|; stage 3 SHALL register L1 sum (MAG_W bits) and gx²+gy² (2·MAG_W−1 bits).
REQ-016 L2 path SHALL use a pipelined restoring square root producing one result bit per stage: MAG_W stages, floor result, exact for all inputs.
REQ-017 L1 path SHALL be delayed by MAG_W stages so both paths have identical latency.
REQ-018 mode and threshold SHALL be captured in stage 1 together with the window and travel down the pipeline with it.
REQ-019 A per-sample mode change SHALL take effect for that sample only.
REQ-020 Final stage SHALL select the path per the carried mode, saturate to 2^OUT_W−1 when the value exceeds OUT_W bits, and register sobel_data and edge_bit.
REQ-021 display_val SHALL equal mean_en delayed by exactly LAT cycles (15 for DATA_W=8), preserving gaps.
REQ-022 When display_val=0, sobel_data and edge_bit SHALL be 0.
REQ-023 threshold = 0 SHALL give edge_bit=1 on every valid sample.
REQ-024 threshold = 2^OUT_W−1 SHALL give edge_bit=1 only on a saturated or exact-maximum sample.

Reset
REQ-025 rst_n low SHALL immediately clear all pipeline registers, valid shift chain, sobel_data, edge_bit and display_val to 0.
REQ-026 Reset mid-stream SHALL discard all in-flight samples.
REQ-027 After reset release, no display_val SHALL be asserted until LAT cycles after the first sampled mean_en=1.

Structure
REQ-028 Package sobel_pkg SHALL hold MODE_L1=0, MODE_L2=1 and the MAG_W/LAT width functions of DATA_W.
REQ-029 Square root SHALL be one sub-module, sobel_sqrt_pipe, parameterised on input width and carrying a sideband (valid, mode, threshold, delayed L1) through its stages.
REQ-030 Target size: 120–400 lines RTL total.

Verification (DATA_W=8, OUT_W=11 unless stated)
REQ-031 All pixels 100, mode=1, threshold=1, one valid cycle -> display_val pulses exactly 15 cycles later with sobel_data=0, edge_bit=0.
REQ-032 p11..p13=0, p31..p33=255, others 0, threshold=500 -> gx=1020, gy=0; mode 0 and mode 1 both give sobel_data=1020, edge_bit=1.
REQ-033 p13=p23=p31=p32=p33=255, others 0 -> |gx|=|gy|=765; mode 0 gives 1530, mode 1 gives 1081; with OUT_W=8 both give 255.
REQ-034 Case REQ-033 streamed continuously with mode toggling every cycle -> outputs alternate 1530/1081 every cycle starting at cycle 15, no bubble.
REQ-035 mean_en pattern 1,0,1,1,0 with random windows -> display_val reproduces 1,0,1,1,0 at +15; outputs are 0 in the gap cycle; values match a software model.
REQ-036 rst_n pulsed low with pipeline full -> all outputs 0 asynchronously; no stale valid appears after release.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the Sobel edge-magnitude pipeline.
package sobel_pkg;

  localparam logic MODE_L1 = 1'b0;
  localparam logic MODE_L2 = 1'b1;

  // Magnitude width: |gx|+|gy| needs DATA_W+3 bits.
  function automatic int unsigned mag_w(input int unsigned data_w);
    return data_w + 3;
  endfunction

  // Three arithmetic stages, one sqrt stage per root bit, one output stage.
  function automatic int unsigned lat(input int unsigned data_w);
    return mag_w(data_w) + 4;
  endfunction

endpackage

// File: rtl/sobel_sqrt_pipe.sv
// Pipelined restoring integer square root, one root bit per stage (MSB first),
// with a valid bit and an opaque sideband carried alongside each sample.
module sobel_sqrt_pipe #(
  parameter int unsigned IN_W = 21,
  parameter int unsigned SB_W = 1,
  localparam int unsigned ROOT_W = (IN_W + 1) / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   radicand,
  input  logic [SB_W-1:0]   in_sb,
  output logic              out_valid,
  output logic [ROOT_W-1:0] root,
  output logic [SB_W-1:0]   out_sb
);

  localparam int unsigned RW = 2 * ROOT_W + 1;

  logic [RW-1:0]     rem_q  [ROOT_W];
  logic [RW-1:0]     rem_d  [ROOT_W];
  logic [ROOT_W-1:0] root_q [ROOT_W];
  logic [ROOT_W-1:0] root_d [ROOT_W];
  logic [SB_W-1:0]   sb_q   [ROOT_W];
  logic [ROOT_W-1:0] vld_q;

  logic [RW-1:0]     rem_in;
  logic [RW-1:0]     trial;
  logic [ROOT_W-1:0] root_in;
  int unsigned       b;

  // rem holds x - root^2; setting bit b adds (root << (b+1)) + 2^(2b) to root^2.
  always_comb begin
    rem_in  = '0;
    trial   = '0;
    root_in = '0;
    b       = 0;
    for (int unsigned s = 0; s < ROOT_W; s++) begin
      if (s == 0) begin
        rem_in  = RW'(radicand);
        root_in = '0;
      end else begin
        rem_in  = rem_q[s-1];
        root_in = root_q[s-1];
      end
      b     = ROOT_W - 1 - s;
      trial = (RW'(root_in) << (b + 1)) + (RW'(1) << (2 * b));
      if (trial <= rem_in) begin
        rem_d[s]  = rem_in - trial;
        root_d[s] = root_in | (ROOT_W'(1) << b);
      end else begin
        rem_d[s]  = rem_in;
        root_d[s] = root_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < ROOT_W; s++) begin
        rem_q[s]  <= '0;
        root_q[s] <= '0;
        sb_q[s]   <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      sb_q[0]  <= in_sb;
      for (int unsigned s = 1; s < ROOT_W; s++) begin
        vld_q[s] <= vld_q[s-1];
        sb_q[s]  <= sb_q[s-1];
      end
      for (int unsigned s = 0; s < ROOT_W; s++) begin
        rem_q[s]  <= rem_d[s];
        root_q[s] <= root_d[s];
      end
    end
  end

  assign out_valid = vld_q[ROOT_W-1];
  assign root      = root_q[ROOT_W-1];
  assign out_sb    = sb_q[ROOT_W-1];

endmodule

// File: rtl/sobel_param.sv
// Streaming 3x3 Sobel gradient magnitude (L1 or floor-L2, per sample) with
// saturation and threshold; fixed latency, one sample per cycle.
module sobel_param
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] matrix_p11,
  input  logic [DATA_W-1:0] matrix_p12,
  input  logic [DATA_W-1:0] matrix_p13,
  input  logic [DATA_W-1:0] matrix_p21,
  input  logic [DATA_W-1:0] matrix_p22,
  input  logic [DATA_W-1:0] matrix_p23,
  input  logic [DATA_W-1:0] matrix_p31,
  input  logic [DATA_W-1:0] matrix_p32,
  input  logic [DATA_W-1:0] matrix_p33,
  input  logic              mean_en,
  input  logic              mode,
  input  logic [OUT_W-1:0]  threshold,
  output logic [OUT_W-1:0]  sobel_data,
  output logic              edge_bit,
  output logic              display_val
);

  localparam int unsigned MAG_W = mag_w(DATA_W);
  localparam int unsigned LAT   = lat(DATA_W);
  localparam int unsigned ABS_W = DATA_W + 2;
  localparam int unsigned SQ_W  = 2 * MAG_W - 1;
  localparam int unsigned SB_W  = 1 + OUT_W + MAG_W;
  localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'((64'd1 << OUT_W) - 64'd1);

  if (LAT != MAG_W + 4) begin : g_lat_check
    $error("sobel_param: pipeline depth does not match LAT");
  end

  // The centre pixel carries no weight in either Sobel kernel.
  logic unused_p22;
  assign unused_p22 = ^matrix_p22;

  function automatic logic [ABS_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] m,
                                            input logic [DATA_W-1:0] c);
    return ABS_W'(a) + (ABS_W'(m) << 1) + ABS_W'(c);
  endfunction

  function automatic logic [ABS_W-1:0] absdiff(input logic [ABS_W-1:0] a,
                                               input logic [ABS_W-1:0] c);
    return (a >= c) ? a - c : c - a;
  endfunction

  // Stage 1: weighted partial sums.
  logic [ABS_W-1:0] gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
  logic             v1_q, mode1_q;
  logic [OUT_W-1:0] thr1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_pos_q <= '0;
      gx_neg_q <= '0;
      gy_pos_q <= '0;
      gy_neg_q <= '0;
      v1_q     <= 1'b0;
      mode1_q  <= MODE_L1;
      thr1_q   <= '0;
    end else begin
      gx_pos_q <= wsum(matrix_p31, matrix_p32, matrix_p33);
      gx_neg_q <= wsum(matrix_p11, matrix_p12, matrix_p13);
      gy_pos_q <= wsum(matrix_p11, matrix_p21, matrix_p31);
      gy_neg_q <= wsum(matrix_p13, matrix_p23, matrix_p33);
      v1_q     <= mean_en;
      mode1_q  <= mode;
      thr1_q   <= threshold;
    end
  end

  // Stage 2: absolute gradients.
  logic [ABS_W-1:0] agx_q, agy_q;
  logic             v2_q, mode2_q;
  logic [OUT_W-1:0] thr2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agx_q   <= '0;
      agy_q   <= '0;
      v2_q    <= 1'b0;
      mode2_q <= MODE_L1;
      thr2_q  <= '0;
    end else begin
      agx_q   <= absdiff(gx_pos_q, gx_neg_q);
      agy_q   <= absdiff(gy_pos_q, gy_neg_q);
      v2_q    <= v1_q;
      mode2_q <= mode1_q;
      thr2_q  <= thr1_q;
    end
  end

  // Stage 3: L1 sum and sum of squares.
  logic [MAG_W-1:0] l1_q;
  logic [SQ_W-1:0]  sq_q;
  logic             v3_q, mode3_q;
  logic [OUT_W-1:0] thr3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_q    <= '0;
      sq_q    <= '0;
      v3_q    <= 1'b0;
      mode3_q <= MODE_L1;
      thr3_q  <= '0;
    end else begin
      l1_q    <= MAG_W'(agx_q) + MAG_W'(agy_q);
      sq_q    <= SQ_W'(agx_q) * SQ_W'(agx_q) + SQ_W'(agy_q) * SQ_W'(agy_q);
      v3_q    <= v2_q;
      mode3_q <= mode2_q;
      thr3_q  <= thr2_q;
    end
  end

  // Square root; the L1 result rides in the sideband to match its latency.
  logic             sq_valid;
  logic [MAG_W-1:0] root;
  logic [SB_W-1:0]  sq_sb;

  sobel_sqrt_pipe #(
    .IN_W (SQ_W),
    .SB_W (SB_W)
  ) u_sqrt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v3_q),
    .radicand  (sq_q),
    .in_sb     ({mode3_q, thr3_q, l1_q}),
    .out_valid (sq_valid),
    .root      (root),
    .out_sb    (sq_sb)
  );

  logic             sb_mode;
  logic [OUT_W-1:0] sb_thr;
  logic [MAG_W-1:0] sb_l1;
  logic [MAG_W-1:0] mag;
  logic [OUT_W-1:0] sat;

  assign {sb_mode, sb_thr, sb_l1} = sq_sb;

  always_comb begin
    mag = (sb_mode == MODE_L2) ? root : sb_l1;
    sat = (mag > SAT_MAX) ? {OUT_W{1'b1}} : mag[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_val <= 1'b0;
      sobel_data  <= '0;
      edge_bit    <= 1'b0;
    end else begin
      display_val <= sq_valid;
      sobel_data  <= sq_valid ? sat : '0;
      edge_bit    <= sq_valid && (sat >= sb_thr);
    end
  end

endmodule

// File: tb/tb_sobel_param.sv
// Scoreboard bench for sobel_param: OUT_W=11 and OUT_W=8 instances share stimulus.
module tb_sobel_param;

  localparam int LAT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  pix [9];
  logic        mean_en, mode;
  logic [10:0] threshold;
  logic [7:0]  thr8;
  assign thr8 = threshold[7:0];

  logic [10:0] data11;
  logic        edge11, dv11;
  logic [7:0]  data8;
  logic        edge8, dv8;

  sobel_param #(.DATA_W(8), .OUT_W(11)) dut11 (
    .clk(clk), .rst_n(rst_n),
    .matrix_p11(pix[0]), .matrix_p12(pix[1]), .matrix_p13(pix[2]),
    .matrix_p21(pix[3]), .matrix_p22(pix[4]), .matrix_p23(pix[5]),
    .matrix_p31(pix[6]), .matrix_p32(pix[7]), .matrix_p33(pix[8]),
    .mean_en(mean_en), .mode(mode), .threshold(threshold),
    .sobel_data(data11), .edge_bit(edge11), .display_val(dv11)
  );

  sobel_param #(.DATA_W(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .matrix_p11(pix[0]), .matrix_p12(pix[1]), .matrix_p13(pix[2]),
    .matrix_p21(pix[3]), .matrix_p22(pix[4]), .matrix_p23(pix[5]),
    .matrix_p31(pix[6]), .matrix_p32(pix[7]), .matrix_p33(pix[8]),
    .mean_en(mean_en), .mode(mode), .threshold(thr8),
    .sobel_data(data8), .edge_bit(edge8), .display_val(dv8)
  );

  typedef struct {
    int data;
    int edge_b;
    int stamp;
  } exp_t;

  exp_t q11[$];
  exp_t q8[$];
  exp_t m11, m8;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int w0[9]   = '{default: 0};
  int w100[9] = '{default: 100};
  int wa[9]   = '{0, 0, 0, 0, 0, 0, 255, 255, 255};
  int wb[9]   = '{0, 0, 255, 0, 0, 255, 255, 255, 255};
  int pat[5]  = '{1, 0, 1, 1, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Independent reference: direct Sobel, brute-force floor sqrt, saturation.
  function automatic int model(input int w[9], input bit md, input int out_w);
    int gx, gy, s, r, mag, mx;
    gx = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
    gy = (w[0] + 2 * w[3] + w[6]) - (w[2] + 2 * w[5] + w[8]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    if (!md) begin
      mag = gx + gy;
    end else begin
      s = gx * gx + gy * gy;
      r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      mag = r;
    end
    mx = (1 << out_w) - 1;
    return (mag > mx) ? mx : mag;
  endfunction

  task automatic send(input bit en, input int w[9], input bit md, input int thr,
                      input int e11, input int e8);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 9; i++) pix[i] = 8'(w[i]);
    mean_en   = en;
    mode      = md;
    threshold = 11'(thr);
    if (en) begin
      e.stamp  = cyc;
      e.data   = e11;
      e.edge_b = (e11 >= thr) ? 1 : 0;
      q11.push_back(e);
      e.data   = e8;
      e.edge_b = (e8 >= (thr % 256)) ? 1 : 0;
      q8.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, w0, 1'b0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (dv11) begin
      if (q11.size() == 0) begin
        check("dut11 unexpected valid", 1, 0);
      end else begin
        m11 = q11.pop_front();
        check("dut11 latency", cyc - m11.stamp, LAT);
        check("dut11 sobel_data", int'(data11), m11.data);
        check("dut11 edge_bit", int'(edge11), m11.edge_b);
      end
    end else begin
      check("dut11 idle outputs", int'({data11, edge11}), 0);
    end
    if (dv8) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected valid", 1, 0);
      end else begin
        m8 = q8.pop_front();
        check("dut8 latency", cyc - m8.stamp, LAT);
        check("dut8 sobel_data", int'(data8), m8.data);
        check("dut8 edge_bit", int'(edge8), m8.edge_b);
      end
    end else begin
      check("dut8 idle outputs", int'({data8, edge8}), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w[9];
    int md, thr;
    mean_en = 1'b0;
    mode = 1'b0;
    threshold = '0;
    for (int i = 0; i < 9; i++) pix[i] = '0;

    repeat (2) @(negedge clk);
    check("reset display_val", int'(dv11), 0);
    check("reset sobel_data", int'(data11), 0);
    check("reset edge_bit", int'(edge11), 0);
    rst_n = 1'b1;
    idle(3);

    // Flat window: zero gradient, exactly 15 cycles of latency.
    send(1'b1, w100, 1'b1, 1, 0, 0);
    idle(20);

    // Horizontal edge, then diagonal edge in both modes.
    send(1'b1, wa, 1'b0, 500, 1020, 255);
    send(1'b1, wa, 1'b1, 500, 1020, 255);
    send(1'b1, wb, 1'b0, 500, 1530, 255);
    send(1'b1, wb, 1'b1, 500, 1081, 255);

    // Per-sample mode toggle on a continuous stream.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, wb, 1'(i % 2), 1000, (i % 2) ? 1081 : 1530, 255);
    end

    // Threshold extremes: 0 always fires; all-ones fires only on saturation.
    send(1'b1, w100, 1'b0, 0, 0, 0);
    send(1'b1, wb, 1'b0, 2047, 1530, 255);
    send(1'b1, wa, 1'b1, 2047, 1020, 255);
    idle(20);

    // Gapped random windows checked against the reference model.
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
        md  = int'($urandom_range(0, 1));
        thr = int'($urandom_range(0, 2047));
        send(1'(pat[k]), w, 1'(md), thr, model(w, 1'(md), 11), model(w, 1'(md), 8));
      end
    end
    idle(20);

    // Reset with the pipeline full and outputs live.
    for (int i = 0; i < 20; i++) send(1'b1, wb, 1'b0, 100, 1530, 255);
    #2;
    rst_n = 1'b0;
    mean_en = 1'b0;
    #1;
    check("async reset display_val", int'(dv11), 0);
    check("async reset sobel_data", int'(data11), 0);
    check("async reset edge_bit", int'(edge11), 0);
    check("async reset dut8 display_val", int'(dv8), 0);
    check("async reset dut8 sobel_data", int'(data8), 0);
    q11.delete();
    q8.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(25);

    send(1'b1, wa, 1'b0, 0, 1020, 255);
    idle(2);

    for (int i = 0; i < 40 && (q11.size() + q8.size()) != 0; i++) @(negedge clk);
    check("scoreboard drained", q11.size() + q8.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
